// File: rtl/reg_init_pkg.sv
// Shared types and widths for the register-bank init loader.
package reg_init_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        HOLD,
        RUN
    } state_t;

endpackage

// File: rtl/reg_init_loader.sv
// Streams words into consecutive bank registers, then hands the bank to the CPU.
// Optional running checksum of accepted words: define REG_INIT_CHECKSUM_EN.
module reg_init_loader
    import reg_init_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int FIRST_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] escribir,
    output logic [ADDR_W-1:0] dirIniciar,
    output logic              EWIniciar,
    output logic              sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    state_t            state, nextState;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              restart;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign restart  = start && (state == IDLE || state == RUN);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start)    nextState = LOAD;
            LOAD:    if (in_valid) nextState = WRITE;
            WRITE:   nextState = HOLD;
            HOLD:    nextState = (addr == LAST_ADDR) ? RUN : LOAD;
            RUN:     if (start)    nextState = LOAD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= FIRST_ADDR;
            escribir   <= '0;
            dirIniciar <= '0;
            EWIniciar  <= 1'b0;
            sel        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state     <= nextState;
            // Write enable is high exactly during WRITE, one cycle per word.
            EWIniciar <= accept;
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        addr <= FIRST_ADDR;
                        sel  <= 1'b0;
                        done <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        escribir   <= in_data;
                        dirIniciar <= addr;
                    end
                end
                HOLD: begin
                    if (addr == LAST_ADDR) begin
                        sel  <= 1'b1;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REG_INIT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || restart)
            checksum <= '0;
        else if (accept)
            checksum <= checksum + in_data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_reg_init_loader.sv
// Scoreboard bench: three loader instances (32/1, 4/0, 4/1) share clock and reset.
module tb_reg_init_loader;

    typedef struct {
        int          k;
        logic [4:0]  addr;
        logic [31:0] data;
    } sbItem_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        startS[3];
    logic        validS[3];
    logic [31:0] dataS[3];
    logic        readyS[3];
    logic [31:0] escS[3];
    logic [4:0]  dirS[3];
    logic        ewS[3];
    logic        selS[3];
    logic        busyS[3];
    logic        doneS[3];
    logic [31:0] chkS[3];

    sbItem_t     sb[$];
    int          errors = 0;
    int          checks = 0;
    int          expAddr[3];
    logic [31:0] expSum[3];
    int          pushCnt[3];
    int          pulseCnt[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        reg_init_loader #(
            .NUM_REGS (g == 0 ? 32 : 4),
            .FIRST_REG(g == 1 ? 0 : 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (startS[g]),
            .in_valid  (validS[g]),
            .in_data   (dataS[g]),
            .in_ready  (readyS[g]),
            .escribir  (escS[g]),
            .dirIniciar(dirS[g]),
            .EWIniciar (ewS[g]),
            .sel       (selS[g]),
            .busy      (busyS[g]),
            .done      (doneS[g]),
            .checksum  (chkS[g])
        );
    end

    // Pulse monitor: every EWIniciar pulse must match the next scoreboard entry.
    for (genvar g = 0; g < 3; g++) begin : mon
        logic        prevEw = 0;
        logic [31:0] prevEsc = 0;
        logic [4:0]  prevDir = 0;
        always @(negedge clk) begin
            sbItem_t it;
            if (ewS[g]) begin
                pulseCnt[g]++;
                checks++;
                if (prevEw) begin
                    errors++;
                    $display("FAIL ew_back_to_back inst %0d: two consecutive write cycles", g);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL ew_unexpected inst %0d: pulse at addr %0d data %h, none expected", g, dirS[g], escS[g]);
                end else begin
                    it = sb.pop_front();
                    if (it.k != g || it.addr !== dirS[g] || it.data !== escS[g]) begin
                        errors++;
                        $display("FAIL ew_write inst %0d: got addr %0d data %h, want inst %0d addr %0d data %h",
                                 g, dirS[g], escS[g], it.k, it.addr, it.data);
                    end
                end
            end else if (prevEw && !rst) begin
                checks++;
                if (escS[g] !== prevEsc || dirS[g] !== prevDir) begin
                    errors++;
                    $display("FAIL hold_stable inst %0d: got addr %0d data %h, want addr %0d data %h",
                             g, dirS[g], escS[g], prevDir, prevEsc);
                end
            end
`ifndef REG_INIT_CHECKSUM_EN
            if (chkS[g] !== 32'h0) begin
                errors++;
                checks++;
                $display("FAIL checksum_tied inst %0d: got %h want 0", g, chkS[g]);
            end
`endif
            prevEw  = ewS[g];
            prevEsc = escS[g];
            prevDir = dirS[g];
        end
    end

    function automatic int firstOf(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int numOf(input int k);
        return (k == 0) ? 32 : 4;
    endfunction

    task automatic pushExp(input int k, input logic [31:0] w);
        sb.push_back('{k: k, addr: 5'(expAddr[k]), data: w});
        expAddr[k]++;
        expSum[k] += w;
        pushCnt[k]++;
    endtask

    // Offer one word after an idle gap; returns at the negedge after acceptance (WRITE).
    task automatic sendWord(input int k, input logic [31:0] w, input int gap);
        int n;
        validS[k] = 0;
        repeat (gap) @(negedge clk);
        validS[k] = 1;
        dataS[k]  = w;
        n = 0;
        while (!readyS[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!readyS[k]) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout inst %0d: in_ready=%b after %0d cycles, want 1", k, readyS[k], n);
        end else begin
            pushExp(k, w);
            @(negedge clk);
        end
        validS[k] = 0;
    endtask

    task automatic startPulse(input int k);
        @(negedge clk);
        startS[k]  = 1;
        expAddr[k] = firstOf(k);
        expSum[k]  = 0;
        @(negedge clk);
        startS[k] = 0;
        checks++;
        if (readyS[k] !== 1 || selS[k] !== 0 || doneS[k] !== 0 || busyS[k] !== 1) begin
            errors++;
            $display("FAIL start_entry inst %0d: got ready=%b sel=%b done=%b busy=%b, want 1 0 0 1",
                     k, readyS[k], selS[k], doneS[k], busyS[k]);
        end
    endtask

    task automatic loadFrom(input int k, input int a0, input int mode);
        logic [31:0] w;
        for (int a = a0; a < numOf(k); a++) begin
            w = (mode != 0) ? 32'($urandom) : 32'h11111111 * 32'(a - firstOf(k) + 1);
            sendWord(k, w, (mode != 0) ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    // Called at the WRITE negedge of the last word: HOLD next, then RUN.
    task automatic checkRun(input int k);
        logic [31:0] expChk;
`ifdef REG_INIT_CHECKSUM_EN
        expChk = expSum[k];
`else
        expChk = 32'h0;
`endif
        @(negedge clk);
        checks++;
        if (doneS[k] !== 0 || selS[k] !== 0) begin
            errors++;
            $display("FAIL hold_early_run inst %0d: got done=%b sel=%b, want 0 0", k, doneS[k], selS[k]);
        end
        @(negedge clk);
        checks++;
        if (doneS[k] !== 1 || selS[k] !== 1 || busyS[k] !== 0 || readyS[k] !== 0 || ewS[k] !== 0) begin
            errors++;
            $display("FAIL run_state inst %0d: got done=%b sel=%b busy=%b ready=%b ew=%b, want 1 1 0 0 0",
                     k, doneS[k], selS[k], busyS[k], readyS[k], ewS[k]);
        end
        checks++;
        if (chkS[k] !== expChk) begin
            errors++;
            $display("FAIL run_checksum inst %0d: got %h want %h", k, chkS[k], expChk);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (escS[k] !== 0 || dirS[k] !== 0 || ewS[k] !== 0 || selS[k] !== 0 ||
                busyS[k] !== 0 || doneS[k] !== 0 || chkS[k] !== 0 || readyS[k] !== 0) begin
                errors++;
                $display("FAIL reset_state inst %0d: esc=%h dir=%0d ew=%b sel=%b busy=%b done=%b chk=%h ready=%b, want all 0",
                         k, escS[k], dirS[k], ewS[k], selS[k], busyS[k], doneS[k], chkS[k], readyS[k]);
            end
        end
        rst = 0;
    endtask

    task automatic test_full_load();
        startPulse(0);
        loadFrom(0, firstOf(0), 0);
        checkRun(0);
    endtask

    task automatic test_random_valid();
        startPulse(0);
        loadFrom(0, firstOf(0), 1);
        checkRun(0);
    endtask

    task automatic test_reset_mid();
        startPulse(0);
        for (int a = 1; a <= 7; a++) sendWord(0, 32'hA0000000 + 32'(a), 0);
        checks++;
        if (ewS[0] !== 1 || dirS[0] !== 5'd7) begin
            errors++;
            $display("FAIL mid_write inst 0: got ew=%b dir=%0d, want 1 7", ewS[0], dirS[0]);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (ewS[0] !== 0 || selS[0] !== 0 || busyS[0] !== 0 || doneS[0] !== 0 ||
            readyS[0] !== 0 || dirS[0] !== 0) begin
            errors++;
            $display("FAIL mid_reset inst 0: got ew=%b sel=%b busy=%b done=%b ready=%b dir=%0d, want all 0",
                     ewS[0], selS[0], busyS[0], doneS[0], readyS[0], dirS[0]);
        end
        @(negedge clk);
        rst = 0;
        startPulse(0);
        sendWord(0, 32'h5EED0001, 0);
        checks++;
        if (ewS[0] !== 1 || dirS[0] !== 5'd1) begin
            errors++;
            $display("FAIL restart_addr inst 0: got ew=%b dir=%0d, want 1 1", ewS[0], dirS[0]);
        end
        loadFrom(0, 2, 0);
        checkRun(0);
    endtask

    task automatic test_start_with_valid();
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        startS[0]  = 1;
        validS[0]  = 1;
        dataS[0]   = 32'hCAFEF00D;
        expAddr[0] = 1;
        expSum[0]  = 0;
        @(negedge clk);
        startS[0] = 0;
        checks++;
        if (readyS[0] !== 1 || ewS[0] !== 0 || busyS[0] !== 1) begin
            errors++;
            $display("FAIL same_cycle_load inst 0: got ready=%b ew=%b busy=%b, want 1 0 1", readyS[0], ewS[0], busyS[0]);
        end
        pushExp(0, 32'hCAFEF00D);
        @(negedge clk);
        validS[0] = 0;
        checks++;
        if (ewS[0] !== 1 || dirS[0] !== 5'd1 || escS[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL same_cycle_write inst 0: got ew=%b dir=%0d esc=%h, want 1 1 cafef00d", ewS[0], dirS[0], escS[0]);
        end
        loadFrom(0, 2, 0);
        checkRun(0);
    endtask

    task automatic test_reload();
        startPulse(1);
        loadFrom(1, 0, 1);
        checkRun(1);
        startPulse(1);
        loadFrom(1, 0, 0);
        checkRun(1);
    endtask

    task automatic test_checksum();
        startPulse(2);
        sendWord(2, 32'hFFFFFFFF, 0);
        sendWord(2, 32'hFFFFFFFF, 1);
        sendWord(2, 32'h00000002, 0);
        checkRun(2);
        startPulse(2);
        loadFrom(2, 1, 1);
        checkRun(2);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            startS[k]   = 0;
            validS[k]   = 0;
            dataS[k]    = 0;
            expAddr[k]  = 0;
            expSum[k]   = 0;
            pushCnt[k]  = 0;
            pulseCnt[k] = 0;
        end
        test_reset();
        test_full_load();
        test_random_valid();
        test_reset_mid();
        test_start_with_valid();
        test_reload();
        test_checksum();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending writes, want 0", sb.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pulseCnt[k] != pushCnt[k]) begin
                errors++;
                $display("FAIL pulse_count inst %0d: got %0d pulses, want %0d", k, pulseCnt[k], pushCnt[k]);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, want completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_init_loader.md
Name: reg_init_loader

Overview:
- Initiator for the CPU top level's register-bank initialisation port: drives escribir, dirIniciar, EWIniciar and sel.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them into consecutive bank registers.
- After the last write it releases the bank to the datapath (sel=1) and signals done.
- Sits beside the CPU top level in the system wrapper and replaces hand-driven testbench init.

Parameters:
- NUM_REGS, 32: number of bank registers; last written address is NUM_REGS-1. Legal range 2..32.
- FIRST_REG, 1: first address written (1 skips $zero). Must satisfy FIRST_REG < NUM_REGS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load sequence.
- in_valid  in  1  in_data is valid.
- in_data  in  32  word to write.
- in_ready  out  1  loader accepts in_data this cycle.
- escribir  out  32  bank write data (to CPU escribir).
- dirIniciar  out  5  bank write address (to CPU dirIniciar).
- EWIniciar  out  1  bank write enable (to CPU EWIniciar).
- sel  out  1  0 = loader owns bank write port; 1 = CPU datapath owns it.
- busy  out  1  load sequence in progress.
- done  out  1  all NUM_REGS-FIRST_REG words written, CPU released.
- checksum  out  32  running sum of accepted words (see Optional Feature).

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs except in_ready, which decodes state only.
- Reset, and the next edge after rst=1:
  - state=IDLE, escribir=0, dirIniciar=0, EWIniciar=0, sel=0, busy=0, done=0, checksum=0, internal address=FIRST_REG.
- States: IDLE, LOAD, WRITE, HOLD, RUN.
- IDLE:
  - in_ready=0, sel=0.
  - start=1 → LOAD; busy=1; address=FIRST_REG; checksum cleared.
- LOAD:
  - in_ready=1; start is ignored.
  - On in_valid&&in_ready: escribir<=in_data, dirIniciar<=address → WRITE.
- WRITE:
  - EWIniciar=1 for exactly one cycle; escribir and dirIniciar are stable → HOLD.
- HOLD:
  - EWIniciar=0; escribir and dirIniciar unchanged (hold time for the level-sensitive bank write).
  - If address==NUM_REGS-1 → RUN. Otherwise address+=1 → LOAD.
- Throughput: 3 cycles per word minimum. in_ready is high only in LOAD. in_valid outside LOAD is ignored and no data is lost, since the source holds in_valid until ready.
- RUN:
  - sel=1, done=1, busy=0, EWIniciar=0.
  - start=1 → LOAD: sel=0, done=0, address=FIRST_REG (reload while CPU is halted by the system).
- Address never wraps; the counter is 5 bits and never exceeds NUM_REGS-1.
- rst asserted mid-sequence (any state) wins over every other input:
  - next edge → IDLE with reset values; EWIniciar drops immediately; a partial load leaves earlier writes in the bank.
- start and in_valid together in IDLE: only start is honoured; the data is accepted the following cycle in LOAD.
- Exactly one EWIniciar pulse per accepted word; never two consecutive EWIniciar=1 cycles.

Optional Feature:
- Macro REG_INIT_CHECKSUM_EN.
- Defined:
  - checksum accumulates a 32-bit wrapping sum of every accepted in_data.
  - Cleared on rst and on entry to LOAD from IDLE/RUN.
  - Stable from entry to RUN until the next start.
- Not defined: checksum is tied to 0; no adder is synthesised.

Decomposition:
- Shared package reg_init_pkg:
  - state enum (IDLE, LOAD, WRITE, HOLD, RUN).
  - constants DATA_W=32 and ADDR_W=5.
- Single module; the FSM and address counter are small enough that no sub-module is warranted.

Test Plan:
- Reset then start; stream words 0x11111111..(31 words, incrementing by 0x11111111 wrapping), FIRST_REG=1, NUM_REGS=32 → 31 EWIniciar pulses at dirIniciar 1..31 with matching escribir; done=1 and sel=1 on the cycle after the HOLD for address 31.
- Source drops in_valid randomly in LOAD → no extra or missing EWIniciar pulses; write order and addresses unchanged; escribir/dirIniciar stable across WRITE and HOLD.
- Assert rst during WRITE at address 7 → next edge EWIniciar=0, sel=0, busy=0, state IDLE; new start restarts at dirIniciar=1.
- In RUN, pulse start → sel falls to 0 and done to 0 the next cycle; a reload of NUM_REGS=4, FIRST_REG=0 writes addresses 0..3 only.
- Start and in_valid in the same cycle in IDLE → word not accepted that cycle; accepted the next cycle; first EWIniciar two cycles after start.
- With REG_INIT_CHECKSUM_EN, load 0xFFFFFFFF twice plus 0x00000002 (NUM_REGS=4, FIRST_REG=1) → checksum=0x00000000 in RUN. Without the macro, checksum=0 throughout.
